// File: rtl/deco_2to4.sv
// Registered binary-to-one-hot (or one-cold) decoder for selects, strobes and demux enables.
// Latency: one cycle from en/in sampled at a rising edge to out/valid.
// Backpressure: none; accepts a new index every cycle, no handshake.
module deco_2to4 #(
   parameter int IN_W       = 2,
   parameter bit ACTIVE_LOW = 1'b0,
   localparam int OUT_W     = 1 << IN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [IN_W-1:0]  in,
   output logic [OUT_W-1:0] out,
   output logic             valid
);

   // Word driven when nothing is selected; XOR with it flips one-hot into one-cold.
   localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};

   // Widths beyond 6 give an impractically wide output; zero width makes no sense.
   if (IN_W < 1 || IN_W > 6) begin : g_bad_in_w
      $error("deco_2to4: IN_W must be in 1..6");
   end

   logic [OUT_W-1:0] one_hot;
   logic [OUT_W-1:0] decoded;

   // Binary index to one-hot, then apply output polarity.
   always_comb begin
      one_hot     = '0;
      one_hot[in] = 1'b1;
      decoded     = one_hot ^ INACTIVE;
   end

   // Output registers: reset wins, a disabled cycle drives the inactive word.
   always_ff @(posedge clk) begin
      if (rst) begin
         out   <= INACTIVE;
         valid <= 1'b0;
      end else if (en) begin
         out   <= decoded;
         valid <= 1'b1;
      end else begin
         out   <= INACTIVE;
         valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_deco_2to4.sv
module tb_deco_2to4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [2:0] in_v = 3'd0;

   logic [3:0] out_a;
   logic       valid_a;
   logic [3:0] out_l;
   logic       valid_l;
   logic [7:0] out_b;
   logic       valid_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Default 2-to-4, active-high.
   deco_2to4 #(.IN_W(2), .ACTIVE_LOW(1'b0)) u_a (
      .clk(clk), .rst(rst), .en(en), .in(in_v[1:0]), .out(out_a), .valid(valid_a)
   );

   // 2-to-4 one-cold.
   deco_2to4 #(.IN_W(2), .ACTIVE_LOW(1'b1)) u_l (
      .clk(clk), .rst(rst), .en(en), .in(in_v[1:0]), .out(out_l), .valid(valid_l)
   );

   // 3-to-8, active-high.
   deco_2to4 #(.IN_W(3), .ACTIVE_LOW(1'b0)) u_b (
      .clk(clk), .rst(rst), .en(en), .in(in_v), .out(out_b), .valid(valid_b)
   );

   // Reference: selected bit is 2^(index mod outputs); disabled/reset gives no selection.
   function automatic logic [7:0] model(input int w, input bit al, input bit r,
                                        input bit e, input int idx);
      int         n;
      logic [7:0] mask;
      logic [7:0] v;
      n    = 1 << w;
      mask = 8'((1 << n) - 1);
      v    = (!r && e) ? 8'(1 << (idx % n)) : 8'h00;
      if (al) v = ~v & mask;
      return v;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one set of inputs, let one edge pass, compare all three instances.
   task automatic step(input bit r, input bit e, input int idx);
      logic [7:0] exp_v;
      rst  = r;
      en   = e;
      in_v = 3'(idx);
      @(posedge clk);
      #1;
      exp_v = (!r && e) ? 8'd1 : 8'd0;
      check("out_a",   {4'b0, out_a}, model(2, 1'b0, r, e, idx));
      check("valid_a", {7'b0, valid_a}, exp_v);
      check("out_l",   {4'b0, out_l}, model(2, 1'b1, r, e, idx));
      check("valid_l", {7'b0, valid_l}, exp_v);
      check("out_b",   out_b, model(3, 1'b0, r, e, idx));
      check("valid_b", {7'b0, valid_b}, exp_v);
      check("ones_b",  8'($countones(out_b)), exp_v);
   endtask

   initial begin
      // Reset held for two edges with en=1, in=3; then release.
      step(1'b1, 1'b1, 3);
      step(1'b1, 1'b1, 3);
      step(1'b0, 1'b1, 3);

      // Full sweep of the 3-bit index (covers 0..3 twice for the 2-bit decoders).
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i);

      // Enable gating.
      step(1'b0, 1'b1, 2);
      step(1'b0, 1'b0, 1);
      step(1'b0, 1'b1, 1);

      // Mid-stream reset pulse.
      step(1'b0, 1'b1, 3);
      step(1'b1, 1'b1, 3);
      step(1'b0, 1'b1, 3);

      // Randomized traffic with occasional reset and disable.
      for (int k = 0; k < 300; k++) begin
         step(bit'($urandom_range(0, 15) == 0),
              bit'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 7)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
